// File: rtl/mem_block_copier.sv
// mem_block_copier: data-memory block copy engine.
// Copies word_count 32-bit words from src_addr to dst_addr, one word every two
// cycles (RD then WR), over the same MemRead/MemWrite/Address/Write_data/Read_data
// port set the CPU datapath uses. Read data is combinational from Address/MemRead.
// Optional build macro MEM_COPY_CHECKSUM_EN adds a running XOR of copied words.
module mem_block_copier #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [31:0]       Write_data,
  input  logic [31:0]       Read_data
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StFin  = 2'd3;

  // Word-align mask; applied as an AND so every address bit is consumed.
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WordStep  = ADDR_W'(4);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [31:0]       buf_q, buf_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d   = src_addr & AlignMask;
          dst_ptr_d   = dst_addr & AlignMask;
          remaining_d = word_count;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_d  = 32'h0;
`endif
          state_d     = (word_count == '0) ? StFin : StRd;
        end
      end
      StRd: begin
        buf_d     = Read_data;
        src_ptr_d = src_ptr_q + WordStep;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d = checksum_q ^ Read_data;
`endif
        state_d   = StWr;
      end
      StWr: begin
        dst_ptr_d   = dst_ptr_q + WordStep;
        remaining_d = remaining_q - CNT_W'(1);
        // remaining_q is the pre-decrement value, so 1 means this was the last word.
        state_d     = (remaining_q == CNT_W'(1)) ? StFin : StRd;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any copy in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buf_q       <= 32'h0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  // Memory strobes and status decoded purely from registered state, so they
  // never glitch with start and MemRead/MemWrite are exclusive by construction.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = 32'h0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StRd: begin
        busy    = 1'b1;
        MemRead = 1'b1;
        Address = src_ptr_q;
      end
      StWr: begin
        busy       = 1'b1;
        MemWrite   = 1'b1;
        Address    = dst_ptr_q;
        Write_data = buf_q;
      end
      StFin: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule
